ddr_cmd_sequencer: RTL

DDR_CMD_SEQUENCER -- requirements
Module: ddr_cmd_sequencer

---
 rtl/ddr_cmd_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ddr_cmd_sequencer.sv
// DDR4 single-access command sequencer: ACT -> (tRCD) -> RD/WR -> (tCAS2PRE)
// -> PRE -> (tRP) -> IDLE. Every output is registered: next-state logic
// computes the pin values for the state being entered so they appear on
// the pins in the same cycle the FSM sits in that state.
module ddr_cmd_sequencer #(
    parameter int T_RCD     = 4,
    parameter int T_CAS2PRE = 8,
    parameter int T_RP      = 4
) (
    input  logic        CK_t,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic        req_bl8,
    input  logic [1:0]  req_bg,
    input  logic [1:0]  req_ba,
    input  logic [16:0] req_row,
    input  logic [9:0]  req_col,
    output logic        cs_n,
    output logic        act_n,
    output logic        RAS_n_A16,
    output logic        CAS_n_A15,
    output logic        WE_n_A14,
    output logic        A13,
    output logic        A12_BC_n,
    output logic        A11,
    output logic        A10_AP,
    output logic [9:0]  A9_A0,
    output logic [1:0]  bg_addr,
    output logic [1:0]  ba_addr,
    output logic        rd_start,
    output logic        wr_start,
    output logic        busy
);
    localparam int T_MAX0 = (T_RCD > T_CAS2PRE) ? T_RCD : T_CAS2PRE;
    localparam int T_MAX  = (T_MAX0 > T_RP) ? T_MAX0 : T_RP;
    localparam int CW     = $clog2(T_MAX + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACT  = 3'd1;
    localparam logic [2:0] S_TRCD = 3'd2;
    localparam logic [2:0] S_CAS  = 3'd3;
    localparam logic [2:0] S_TCP  = 3'd4;
    localparam logic [2:0] S_PRE  = 3'd5;
    localparam logic [2:0] S_TRP  = 3'd6;

    // The wait states already last one cycle on entry, so they load T-2 and
    // leave when the counter reaches zero; T >= 2 keeps the load non-negative.
    localparam logic [CW-1:0] LD_RCD = CW'(T_RCD - 2);
    localparam logic [CW-1:0] LD_CP  = CW'(T_CAS2PRE - 2);
    localparam logic [CW-1:0] LD_RP  = CW'(T_RP - 2);

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_wr, r_bl8;
    logic [1:0]    r_bg, r_ba;
    logic [9:0]    r_col;

    logic          w_accept;
    logic [2:0]    w_nstate;
    logic [CW-1:0] w_ncnt;
    logic [4:0]    w_pins;
    logic [3:0]    w_a13_a10;
    logic [9:0]    w_a9_a0;
    logic [1:0]    w_bg, w_ba;
    logic          w_rd, w_wrs;

    // req_ready is a register that is 1 only while in IDLE
    assign w_accept = req_ready & req_valid;

    // Next state and wait-counter reload on every state entry
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        case (r_state)
            S_IDLE: if (w_accept) begin w_nstate = S_ACT; w_ncnt = '0; end
            S_ACT:  begin w_nstate = S_TRCD; w_ncnt = LD_RCD; end
            S_TRCD: if (r_cnt == '0) begin w_nstate = S_CAS; w_ncnt = '0; end
                    else w_ncnt = r_cnt - 1'b1;
            S_CAS:  begin w_nstate = S_TCP; w_ncnt = LD_CP; end
            S_TCP:  if (r_cnt == '0) begin w_nstate = S_PRE; w_ncnt = '0; end
                    else w_ncnt = r_cnt - 1'b1;
            S_PRE:  begin w_nstate = S_TRP; w_ncnt = LD_RP; end
            S_TRP:  if (r_cnt == '0) begin w_nstate = S_IDLE; w_ncnt = '0; end
                    else w_ncnt = r_cnt - 1'b1;
            default: begin w_nstate = S_IDLE; w_ncnt = '0; end
        endcase
    end

    // Pin values for the state being entered; ACT is only entered on
    // acceptance, so it takes the address straight from the request.
    always_comb begin
        w_pins    = 5'b11111;
        w_a13_a10 = 4'b0;
        w_a9_a0   = 10'b0;
        w_bg      = 2'b0;
        w_ba      = 2'b0;
        w_rd      = 1'b0;
        w_wrs     = 1'b0;
        case (w_nstate)
            S_ACT: begin
                w_pins    = {2'b00, req_row[16:14]};
                w_a13_a10 = req_row[13:10];
                w_a9_a0   = req_row[9:0];
                w_bg      = req_bg;
                w_ba      = req_ba;
            end
            S_CAS: begin
                w_pins    = {4'b0110, ~r_wr};
                w_a13_a10 = {1'b0, r_bl8, 2'b00};
                w_a9_a0   = r_col;
                w_bg      = r_bg;
                w_ba      = r_ba;
                w_rd      = ~r_wr;
                w_wrs     = r_wr;
            end
            S_PRE: begin
                w_pins = 5'b01010;
                w_bg   = r_bg;
                w_ba   = r_ba;
            end
            default: ;
        endcase
    end

    // State, counter, captured request and registered outputs
    always_ff @(posedge CK_t) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_wr      <= 1'b0;
            r_bl8     <= 1'b0;
            r_bg      <= 2'b0;
            r_ba      <= 2'b0;
            r_col     <= 10'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} <= 5'b11111;
            {A13, A12_BC_n, A11, A10_AP} <= 4'b0;
            A9_A0     <= 10'b0;
            bg_addr   <= 2'b0;
            ba_addr   <= 2'b0;
            rd_start  <= 1'b0;
            wr_start  <= 1'b0;
        end else begin
            r_state   <= w_nstate;
            r_cnt     <= w_ncnt;
            if (w_accept) begin
                r_wr  <= req_wr;
                r_bl8 <= req_bl8;
                r_bg  <= req_bg;
                r_ba  <= req_ba;
                r_col <= req_col;
            end
            req_ready <= (w_nstate == S_IDLE);
            busy      <= (w_nstate != S_IDLE);
            {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} <= w_pins;
            {A13, A12_BC_n, A11, A10_AP} <= w_a13_a10;
            A9_A0     <= w_a9_a0;
            bg_addr   <= w_bg;
            ba_addr   <= w_ba;
            rd_start  <= w_rd;
            wr_start  <= w_wrs;
        end
    end
endmodule
